// File: rtl/btb_port_arbiter_if.sv
// Bundles the fetch lookup, execute update and BTB port signals that meet at
// the BTB port arbiter.
interface btb_port_arbiter_if;
  logic        lk_req;
  logic [31:0] lk_pc;
  logic        lk_resp;
  logic        lk_hit;
  logic [31:0] lk_target;

  logic        up_valid;
  logic [31:0] up_pc;
  logic [31:0] up_target;
  logic        up_ready;

  logic        btb_read;
  logic        btb_write;
  logic [31:0] btb_addr;
  logic [31:0] btb_wdata;
  logic [31:0] btb_rdata;
  logic        btb_hit;
  logic        btb_resp;

  // Arbiter side.
  modport slave (
    input  lk_req, lk_pc, up_valid, up_pc, up_target,
           btb_rdata, btb_hit, btb_resp,
    output lk_resp, lk_hit, lk_target, up_ready,
           btb_read, btb_write, btb_addr, btb_wdata
  );

  // Environment side: fetch, execute and the BTB itself.
  modport master (
    output lk_req, lk_pc, up_valid, up_pc, up_target,
           btb_rdata, btb_hit, btb_resp,
    input  lk_resp, lk_hit, lk_target, up_ready,
           btb_read, btb_write, btb_addr, btb_wdata
  );
endinterface

// File: rtl/btb_port_arbiter.sv
// Arbitrates the single BTB port between fetch lookups and queued execute
// updates, forwarding still-queued targets to lookups.
module btb_port_arbiter #(
  parameter int QDEPTH     = 2,
  parameter int STARVE_MAX = 4
) (
  input logic               clk,
  input logic               rst_n,
  btb_port_arbiter_if.slave bus
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE} state_e;

  state_e        state_q;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [SW-1:0] starve_q;
  logic [31:0]   addr_q, wdata_q;
  logic [31:0]   fifo_pc_q  [QDEPTH];
  logic [31:0]   fifo_tgt_q [QDEPTH];

  logic          full, nonempty, starved, push, pop;
  logic          go_update, go_lookup;
  logic          fwd_hit;
  logic [31:0]   fwd_tgt;
  logic [PW-1:0] idx;

  assign full      = (count_q == CW'(QDEPTH));
  assign nonempty  = (count_q != '0);
  assign starved   = (starve_q == SW'(STARVE_MAX));
  assign push      = bus.up_valid && !full;
  assign pop       = (state_q == UPDATE) && bus.btb_resp;
  assign go_update = full || (nonempty && starved) || (nonempty && !bus.lk_req);
  assign go_lookup = bus.lk_req && !full && !(nonempty && starved);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      starve_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case (state_q)
        IDLE: begin
          if (go_update) begin
            state_q  <= UPDATE;
            addr_q   <= fifo_pc_q[rd_ptr_q];
            wdata_q  <= fifo_tgt_q[rd_ptr_q];
            starve_q <= '0;
          end else if (go_lookup) begin
            state_q <= LOOKUP;
            addr_q  <= bus.lk_pc;
            // Only lookups that overtake a pending update count as starvation.
            if (nonempty && !starved) starve_q <= starve_q + SW'(1);
          end
        end
        LOOKUP:  if (bus.btb_resp) state_q <= IDLE;
        UPDATE:  if (bus.btb_resp) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Queue storage carries no reset; occupancy and pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc_q[wr_ptr_q]  <= bus.up_pc;
      fifo_tgt_q[wr_ptr_q] <= bus.up_target;
    end
  end

  // Scan oldest to newest so the newest matching entry is the one kept.
  always_comb begin
    fwd_hit = 1'b0;
    fwd_tgt = '0;
    idx     = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fifo_pc_q[idx] == addr_q)) begin
        fwd_hit = 1'b1;
        fwd_tgt = fifo_tgt_q[idx];
      end
    end
  end

  assign bus.lk_resp   = (state_q == LOOKUP) && bus.btb_resp;
  assign bus.lk_hit    = bus.lk_resp && (fwd_hit || bus.btb_hit);
  assign bus.lk_target = !bus.lk_resp ? '0 : (fwd_hit ? fwd_tgt : bus.btb_rdata);
  assign bus.up_ready  = !full;
  assign bus.btb_read  = (state_q == LOOKUP);
  assign bus.btb_write = (state_q == UPDATE);
  assign bus.btb_addr  = addr_q;
  assign bus.btb_wdata = wdata_q;

endmodule

// File: tb/tb_btb_port_arbiter.sv
// Self-checking bench for btb_port_arbiter: BTB responder, queue-based
// reference model, directed corner cases and a randomized run.
module tb_btb_port_arbiter;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } upd_t;

  typedef struct {
    logic [31:0] pc;
    bit          pre;
    logic [31:0] data;
    int          lat;
    logic        exp_hit;
    logic [31:0] exp_tgt;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  btb_port_arbiter_if bif();
  btb_port_arbiter #(.QDEPTH(2), .STARVE_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int          tests = 0;
  int          fails = 0;
  upd_t        pend[$];
  upd_t        wr_log[$];
  logic [31:0] btb_mem [logic [31:0]];
  int          lat = 0;
  bit          rand_lat = 1'b0;
  bit          hold = 1'b0;
  int          wr_cycles = 0;
  logic [31:0] cur_lk_pc = '0;
  int          rsp_cnt = 0;
  int          rsp_cur = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // BTB responder: answers after rsp_cur extra cycles; same-cycle when zero.
  initial begin
    bif.btb_resp  = 1'b0;
    bif.btb_hit   = 1'b0;
    bif.btb_rdata = '0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n || !(bif.btb_read || bif.btb_write)) begin
        bif.btb_resp = 1'b0;
        bif.btb_hit  = 1'b0;
        rsp_cnt      = 0;
      end else begin
        if (rsp_cnt == 0) rsp_cur = rand_lat ? int'($urandom_range(0, 3)) : lat;
        if (!hold && rsp_cnt >= rsp_cur) begin
          bif.btb_resp  = 1'b1;
          bif.btb_hit   = bif.btb_read && btb_mem.exists(bif.btb_addr);
          bif.btb_rdata = btb_mem.exists(bif.btb_addr) ? btb_mem[bif.btb_addr]
                                                       : (32'hDEAD_0000 ^ bif.btb_addr);
        end else begin
          bif.btb_resp = 1'b0;
        end
        rsp_cnt++;
      end
    end
  end

  // Reference model: pend mirrors the update queue as a plain ordered list.
  initial begin
    logic        e_hit;
    logic [31:0] e_tgt;
    forever begin
      @(posedge clk); #3;
      if (!rst_n) begin
        pend.delete();
        continue;
      end
      chk("one_owner", 32'(bif.btb_read && bif.btb_write), 0);
      chk("up_ready", 32'(bif.up_ready), 32'(pend.size() != 2));
      if (bif.btb_read) chk("rd_addr", bif.btb_addr, cur_lk_pc);
      if (bif.btb_write) begin
        wr_cycles++;
        if (pend.size() == 0) fail_now("write_with_empty_queue");
        else begin
          chk("wr_addr", bif.btb_addr, pend[0].pc);
          chk("wr_data", bif.btb_wdata, pend[0].tgt);
          if (bif.btb_resp) begin
            wr_log.push_back(pend[0]);
            btb_mem[pend[0].pc] = pend[0].tgt;
            void'(pend.pop_front());
          end
        end
      end
      if (bif.lk_resp) begin
        e_hit = btb_mem.exists(cur_lk_pc);
        e_tgt = e_hit ? btb_mem[cur_lk_pc] : (32'hDEAD_0000 ^ cur_lk_pc);
        foreach (pend[i]) if (pend[i].pc == cur_lk_pc) begin
          e_hit = 1'b1;
          e_tgt = pend[i].tgt;
        end
        chk("lk_hit", 32'(bif.lk_hit), 32'(e_hit));
        chk("lk_target", bif.lk_target, e_tgt);
      end
      if (bif.up_valid && bif.up_ready) pend.push_back('{bif.up_pc, bif.up_target});
    end
  end

  task automatic do_lookup(input logic [31:0] pc, output logic hit,
                           output logic [31:0] tgt, output int lcy);
    @(posedge clk); #1;
    bif.lk_req = 1'b1;
    bif.lk_pc  = pc;
    cur_lk_pc  = pc;
    lcy = 0; hit = 1'b0; tgt = '0;
    #3;
    while (!bif.lk_resp && lcy < 50) begin
      @(posedge clk); #4;
      lcy++;
    end
    if (!bif.lk_resp) fail_now("lookup_timeout");
    else begin
      hit = bif.lk_hit;
      tgt = bif.lk_target;
    end
  endtask

  task automatic lk_idle();
    @(posedge clk); #1;
    bif.lk_req = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] tgt);
    int n;
    @(posedge clk); #1;
    bif.up_valid  = 1'b1;
    bif.up_pc     = pc;
    bif.up_target = tgt;
    n = 0;
    while (!bif.up_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bif.up_ready) fail_now("push_timeout");
  endtask

  task automatic up_idle();
    @(posedge clk); #1;
    bif.up_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk); #4;
      n++;
    end while ((pend.size() != 0 || bif.btb_write || bif.btb_read) && n < 200);
    chk("drain", 32'(pend.size()), 0);
  endtask

  vec_t        tbl[4];
  logic        h, h2;
  logic [31:0] t, t2;
  int          l, n, ph, cnt_a, cnt_b, after, nwr, wr0, wrc0;
  bit          pushed_now, lk_busy;

  initial begin
    tbl[0] = '{32'h100, 1'b1, 32'h180, 0, 1'b1, 32'h180,      1};
    tbl[1] = '{32'h140, 1'b0, 32'h0,   0, 1'b0, 32'hDEAD_0140, 1};
    tbl[2] = '{32'h104, 1'b1, 32'h1F0, 2, 1'b1, 32'h1F0,      3};
    tbl[3] = '{32'h108, 1'b0, 32'h0,   3, 1'b0, 32'hDEAD_0108, 4};

    bif.lk_req = 1'b0; bif.lk_pc = '0;
    bif.up_valid = 1'b0; bif.up_pc = '0; bif.up_target = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_btb_read",  32'(bif.btb_read), 0);
    chk("rst_btb_write", 32'(bif.btb_write), 0);
    chk("rst_btb_addr",  bif.btb_addr, 0);
    chk("rst_btb_wdata", bif.btb_wdata, 0);
    chk("rst_lk_resp",   32'(bif.lk_resp), 0);
    chk("rst_lk_hit",    32'(bif.lk_hit), 0);
    chk("rst_lk_target", bif.lk_target, 0);
    chk("rst_up_ready",  32'(bif.up_ready), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle lookups from the vector table.
    foreach (tbl[i]) begin
      if (tbl[i].pre) btb_mem[tbl[i].pc] = tbl[i].data;
      lat = tbl[i].lat;
      do_lookup(tbl[i].pc, h, t, l);
      chk($sformatf("tbl%0d_hit", i), 32'(h), 32'(tbl[i].exp_hit));
      chk($sformatf("tbl%0d_tgt", i), t, tbl[i].exp_tgt);
      chk($sformatf("tbl%0d_lat", i), 32'(l), 32'(tbl[i].exp_lat));
    end
    lk_idle();
    repeat (3) @(posedge clk);
    chk("tbl_no_write", 32'(wr_cycles), 0);

    // Forwarding from the queue, newest entry wins.
    lat = 5;
    fork
      do_lookup(32'h300, h, t, l);
      begin @(posedge clk); push(32'h200, 32'h240); up_idle(); end
    join
    do_lookup(32'h200, h, t, l);
    chk("fwd_hit", 32'(h), 1);
    chk("fwd_tgt", t, 32'h240);
    fork
      do_lookup(32'h200, h2, t2, l);
      begin push(32'h200, 32'h260); up_idle(); end
    join
    chk("fwd_newest_hit", 32'(h2), 1);
    chk("fwd_newest_tgt", t2, 32'h260);
    lk_idle();
    wait_idle();
    lat = 0;
    do_lookup(32'h200, h, t, l);
    chk("btb_after_drain", t, 32'h260);
    lk_idle();

    // Full queue beats a held lookup request.
    lat = 2;
    fork
      do_lookup(32'h400, h, t, l);
      begin @(posedge clk); push(32'h500, 32'h501); push(32'h510, 32'h511); up_idle(); end
    join
    chk("full_up_ready", 32'(bif.up_ready), 0);
    lat = 0;
    @(posedge clk); #4;
    @(posedge clk); #4;
    chk("full_write", 32'(bif.btb_write), 1);
    chk("full_no_read", 32'(bif.btb_read), 0);
    chk("full_oldest_pc", bif.btb_addr, 32'h500);
    chk("full_oldest_tgt", bif.btb_wdata, 32'h501);
    lk_idle();
    wait_idle();

    // Starvation: each queued entry waits exactly four overtaking lookups.
    bif.lk_req = 1'b1; bif.lk_pc = 32'h700; cur_lk_pc = 32'h700;
    ph = 0; cnt_a = 0; cnt_b = 0; after = 0; nwr = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      bif.up_valid = 1'b0;
      pushed_now = 1'b0;
      if (((ph == 0 && c >= 3) || (ph == 2 && c >= 30)) && bif.btb_read) begin
        bif.up_valid  = 1'b1;
        bif.up_pc     = (ph == 0) ? 32'h600 : 32'h610;
        bif.up_target = (ph == 0) ? 32'h601 : 32'h611;
        ph++;
        pushed_now = 1'b1;
      end
      #3;
      if (!pushed_now && bif.lk_resp) begin
        if (ph == 1) cnt_a++;
        else if (ph == 3) cnt_b++;
        else if (ph == 4) after++;
      end
      if (bif.btb_write && bif.btb_resp) begin
        nwr++;
        if (ph == 1 || ph == 3) ph++;
      end
    end
    chk("starve_first", 32'(cnt_a), 4);
    chk("starve_cleared", 32'(cnt_b), 4);
    chk("starve_writes", 32'(nwr), 2);
    chk("starve_resume", 32'(after > 0), 1);
    n = 0;
    while (!bif.lk_resp && n < 20) begin @(posedge clk); #4; n++; end
    lk_idle();
    wait_idle();

    // Reset while a write is stalled.
    hold = 1'b1;
    push(32'h800, 32'h801);
    up_idle();
    n = 0;
    while (!bif.btb_write && n < 20) begin @(posedge clk); #4; n++; end
    if (!bif.btb_write) fail_now("reset_write_wait");
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_write", 32'(bif.btb_write), 0);
    chk("rst_mid_ready", 32'(bif.up_ready), 1);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    hold = 1'b0;
    wr0 = wr_log.size(); wrc0 = wr_cycles;
    do_lookup(32'h900, h, t, l);
    chk("rst_lk_lat", 32'(l), 1);
    lk_idle();
    repeat (4) @(posedge clk);
    chk("rst_no_write", 32'(wr_cycles - wrc0), 0);

    // Pointer wrap-around: ten updates in order.
    rand_lat = 1'b1;
    for (int i = 0; i < 10; i++) push(32'(4 * i), 32'h1000 + 32'(i));
    up_idle();
    wait_idle();
    chk("wrap_count", 32'(wr_log.size() - wr0), 10);
    for (int i = 0; i < 10; i++) if (wr0 + i < wr_log.size()) begin
      chk($sformatf("wrap%0d_pc", i), wr_log[wr0 + i].pc, 32'(4 * i));
      chk($sformatf("wrap%0d_tgt", i), wr_log[wr0 + i].tgt, 32'h1000 + 32'(i));
    end

    // Randomized traffic checked by the reference model.
    lk_busy = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (!lk_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          bif.lk_req = 1'b1;
          bif.lk_pc  = 32'($urandom_range(0, 15)) << 2;
          cur_lk_pc  = bif.lk_pc;
          lk_busy    = 1'b1;
        end else bif.lk_req = 1'b0;
      end
      bif.up_valid  = $urandom_range(0, 1) == 1;
      bif.up_pc     = 32'($urandom_range(0, 15)) << 2;
      bif.up_target = $urandom;
      #3;
      if (lk_busy && bif.lk_resp) lk_busy = 1'b0;
    end
    n = 0;
    while (lk_busy && n < 50) begin
      @(posedge clk); #4;
      if (bif.lk_resp) lk_busy = 1'b0;
      n++;
    end
    if (lk_busy) fail_now("rand_lookup_wait");
    @(posedge clk); #1;
    bif.lk_req = 1'b0;
    bif.up_valid = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
